// File: rtl/morph_debug_sequencer_if.sv
// rtl/morph_debug_sequencer_if.sv - program, run-control, processor and byte-stream signals of the debug sequencer
interface morph_debug_sequencer_if #(
  parameter int ImageWidth   = 8,
  parameter int ImageHeight  = 4,
  parameter int ProgramDepth = 4
);
  localparam int AW = $clog2(ProgramDepth);
  localparam int N  = ImageWidth * ImageHeight;

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          start;
  logic [AW:0]   op_count;
  logic          proc_ce;
  logic [15:0]   proc_opcode;
  logic          proc_done;
  logic [N-1:0]  proc_image;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  // master is the sequencer itself; slave is the host/processor/sink side
  modport master (
    input  prog_we, prog_addr, prog_data, start, op_count, proc_done, proc_image, tx_ready,
    output proc_ce, proc_opcode, tx_data, tx_valid, busy, done
  );

  modport slave (
    output prog_we, prog_addr, prog_data, start, op_count, proc_done, proc_image, tx_ready,
    input  proc_ce, proc_opcode, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/morph_debug_sequencer.sv
// rtl/morph_debug_sequencer.sv - runs a stored opcode program on the morphology processor and streams the result image out bytewise
// Optional two-byte run header (0xA5, op count) is enabled by defining MORPH_DEBUG_HEADER_EN.
module morph_debug_sequencer #(
  parameter int ImageWidth   = 8,
  parameter int ImageHeight  = 4,
  parameter int ProgramDepth = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  morph_debug_sequencer_if.master bus
);
  localparam int AW     = $clog2(ProgramDepth);
  localparam int CW     = AW + 1;
  localparam int N      = ImageWidth * ImageHeight;
  localparam int NBYTES = N / 8;
  localparam int BW     = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
`ifdef MORPH_DEBUG_HEADER_EN
    S_HDR   = 3'd3,
`endif
    S_SEND  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [15:0]   r_prog [ProgramDepth];
  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_op_count;
  logic [N-1:0]  r_shift;
  logic [BW-1:0] r_byte_cnt;
  logic          r_start;
  logic          r_done_q;
`ifdef MORPH_DEBUG_HEADER_EN
  logic          r_hdr_sel;
`endif

  logic          w_start_acc;
  logic          w_last;
  logic          w_xfer;
  logic [CW-1:0] w_clamped;
  logic          w_proc_ce;
  logic [15:0]   w_proc_opcode;
  logic [7:0]    w_tx_data;
  logic          w_tx_valid;
  logic          w_done;

  // start and proc_done pass through one input register, giving the two-cycle step latency
  assign w_start_acc = bus.start && (r_state == S_IDLE) && !r_start;
  assign w_clamped   = (r_op_count > CW'(ProgramDepth)) ? CW'(ProgramDepth) : r_op_count;
  assign w_last      = ({1'b0, r_idx} == (r_count - 1'b1));
  assign w_xfer      = w_tx_valid && bus.tx_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_count    <= '0;
      r_op_count <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_start    <= 1'b0;
      r_done_q   <= 1'b0;
`ifdef MORPH_DEBUG_HEADER_EN
      r_hdr_sel  <= 1'b0;
`endif
      for (int k = 0; k < ProgramDepth; k++) begin
        r_prog[k] <= '0;
      end
    end else begin
      r_state  <= w_next_state;
      r_start  <= w_start_acc;
      r_done_q <= bus.proc_done && (r_state == S_WAIT) && !r_done_q;
      if (w_start_acc) begin
        r_op_count <= bus.op_count;
      end
      if ((r_state == S_IDLE) && bus.prog_we) begin
        r_prog[bus.prog_addr] <= bus.prog_data;
      end
      case (r_state)
        S_IDLE: begin
          if (r_start) begin
            r_idx      <= '0;
            r_count    <= w_clamped;
            r_byte_cnt <= '0;
`ifdef MORPH_DEBUG_HEADER_EN
            r_hdr_sel  <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          // image is taken on the processor's own done cycle, not the delayed copy
          if (bus.proc_done && !r_done_q && w_last) begin
            r_shift <= bus.proc_image;
          end
          if (r_done_q && !w_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
`ifdef MORPH_DEBUG_HEADER_EN
        S_HDR: begin
          if (w_xfer) begin
            r_hdr_sel <= 1'b1;
          end
        end
`endif
        S_SEND: begin
          if (w_xfer) begin
            r_shift    <= r_shift << 8;
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_start) begin
`ifdef MORPH_DEBUG_HEADER_EN
          w_next_state = (w_clamped == '0) ? S_HDR : S_ISSUE;
`else
          w_next_state = (w_clamped == '0) ? S_FIN : S_ISSUE;
`endif
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (r_done_q) begin
`ifdef MORPH_DEBUG_HEADER_EN
          w_next_state = w_last ? S_HDR : S_ISSUE;
`else
          w_next_state = w_last ? S_SEND : S_ISSUE;
`endif
        end
      end
`ifdef MORPH_DEBUG_HEADER_EN
      S_HDR: begin
        if (w_xfer && r_hdr_sel) begin
          w_next_state = (r_count == '0) ? S_FIN : S_SEND;
        end
      end
`endif
      S_SEND: begin
        if (w_xfer && (r_byte_cnt == BW'(NBYTES - 1))) begin
          w_next_state = S_FIN;
        end
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_proc_ce     = 1'b0;
    w_proc_opcode = '0;
    w_tx_data     = '0;
    w_tx_valid    = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_ISSUE: begin
        w_proc_ce     = 1'b1;
        w_proc_opcode = r_prog[r_idx];
      end
      S_WAIT: w_proc_opcode = r_prog[r_idx];
`ifdef MORPH_DEBUG_HEADER_EN
      S_HDR: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_hdr_sel ? 8'(r_count) : 8'hA5;
      end
`endif
      S_SEND: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_shift[N-1 -: 8];
      end
      S_FIN:   w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.proc_ce     = w_proc_ce;
  assign bus.proc_opcode = w_proc_opcode;
  assign bus.tx_data     = w_tx_data;
  assign bus.tx_valid    = w_tx_valid;
  assign bus.done        = w_done;
  assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_morph_debug_sequencer.sv
// tb/tb_morph_debug_sequencer.sv - self-checking bench for morph_debug_sequencer against a queue-based run model
module tb_morph_debug_sequencer;
  localparam int IW = 8;
  localparam int IH = 4;
  localparam int PD = 4;
  localparam int N  = IW * IH;
  localparam int NB = N / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  morph_debug_sequencer_if #(.ImageWidth(IW), .ImageHeight(IH), .ProgramDepth(PD)) bus ();
  morph_debug_sequencer #(.ImageWidth(IW), .ImageHeight(IH), .ProgramDepth(PD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0]  model_prog [PD];
  logic [N-1:0] img_for_op [PD];
  logic [15:0]  exp_ops [$];
  logic [7:0]   exp_bytes [$];
  int resp_idx = 0;
  int ready_mode = 0;
  int done_seen = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int last_done_cyc = -1;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [3:0] ready_pat = 4'b1001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.tx_ready = 1'b1;
      1: bus.tx_ready = ready_pat[3 - (cyc % 4)];
      2: bus.tx_ready = 1'($urandom_range(0, 1));
      3: bus.tx_ready = 1'b0;
      default: ;
    endcase
  end

  // processor stand-in: result 3 cycles after each issue, junk image otherwise
  always begin
    @(negedge clk);
    if (rst && bus.proc_ce) begin
      int k;
      k = resp_idx % PD;
      resp_idx++;
      repeat (3) @(posedge clk);
      #1;
      bus.proc_done  = 1'b1;
      bus.proc_image = img_for_op[k];
      @(posedge clk);
      #1;
      bus.proc_done  = 1'b0;
      bus.proc_image = $urandom;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus.proc_done) last_done_cyc = cyc;
      if (bus.proc_ce) begin
        checks++;
        if (exp_ops.size() == 0) begin
          errors++;
          $display("FAIL unexpected_proc_ce actual=%0h required=none", bus.proc_opcode);
        end else if (bus.proc_opcode !== exp_ops[0]) begin
          errors++;
          $display("FAIL proc_opcode actual=%0h required=%0h", bus.proc_opcode, exp_ops[0]);
          void'(exp_ops.pop_front());
        end else begin
          void'(exp_ops.pop_front());
        end
        if (last_done_cyc >= 0) check("issue_latency", 32'(cyc - last_done_cyc), 32'd2);
      end
      if (prev_valid && !prev_ready) begin
        check("tx_valid_held", 32'(bus.tx_valid), 32'd1);
        check("tx_data_stable", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        checks++;
        if (exp_bytes.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", bus.tx_data);
        end else if (bus.tx_data !== exp_bytes[0]) begin
          errors++;
          $display("FAIL tx_byte actual=%0h required=%0h", bus.tx_data, exp_bytes[0]);
          void'(exp_bytes.pop_front());
        end else begin
          void'(exp_bytes.pop_front());
        end
      end
      if (bus.done) begin
        done_seen++;
        done_cyc = cyc;
        check("ops_left_at_done", 32'(exp_ops.size()), 32'd0);
        check("bytes_left_at_done", 32'(exp_bytes.size()), 32'd0);
      end
      prev_valid = bus.tx_valid;
      prev_ready = bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  task automatic prog_write(input int addr, input logic [15:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 2'(addr);
    bus.prog_data = data;
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
    model_prog[addr] = data;
  endtask

  task automatic build_model(input int op);
    int cnt;
    cnt = (op > PD) ? PD : op;
    for (int i = 0; i < cnt; i++) exp_ops.push_back(model_prog[i]);
`ifdef MORPH_DEBUG_HEADER_EN
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'(cnt));
`endif
    if (cnt > 0) begin
      for (int b = 0; b < NB; b++) exp_bytes.push_back(img_for_op[cnt-1][N-1-8*b -: 8]);
    end
  endtask

  task automatic pulse_start(input int op);
    resp_idx      = 0;
    last_done_cyc = -1;
    bus.start     = 1'b1;
    bus.op_count  = 3'(op);
    start_cyc     = cyc;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.op_count = 3'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_seen;
    n = 0;
    while (done_seen == d0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(done_seen - d0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic directed_queues();
    exp_ops.push_back(16'h5D11);
    exp_ops.push_back(16'h4911);
`ifdef MORPH_DEBUG_HEADER_EN
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h02);
`endif
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h30);
    exp_bytes.push_back(8'h18);
    exp_bytes.push_back(8'h00);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_proc_ce"}, 32'(bus.proc_ce), 32'd0);
    check({tag, "_opcode"}, 32'(bus.proc_opcode), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = '0;
    bus.start      = 1'b0;
    bus.op_count   = '0;
    bus.proc_done  = 1'b0;
    bus.proc_image = '0;
    bus.tx_ready   = 1'b1;
    for (int i = 0; i < PD; i++) begin
      model_prog[i] = '0;
      img_for_op[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // canonical two-opcode run, full-rate sink
    prog_write(0, 16'h5D11);
    prog_write(1, 16'h4911);
    img_for_op[0] = 32'hDEADBEEF;
    img_for_op[1] = 32'h00301800;
    ready_mode = 0;
    directed_queues();
    pulse_start(2);
    wait_done("run_basic_done", 200);

    // same run, sink stalls in a 1,0,0,1 pattern
    ready_mode = 1;
    directed_queues();
    pulse_start(2);
    wait_done("run_stall_done", 300);
    ready_mode = 0;

    // zero-length run
    build_model(0);
    pulse_start(0);
    wait_done("run_zero_done", 100);
`ifndef MORPH_DEBUG_HEADER_EN
    check("zero_done_latency", 32'(done_cyc - start_cyc), 32'd2);
`endif

    // start and prog_we during WAIT must be ignored
    directed_queues();
    pulse_start(2);
    n = 0;
    while (!bus.proc_ce && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("saw_first_issue", 32'(bus.proc_ce), 32'd1);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.op_count  = 3'd1;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 2'd0;
    bus.prog_data = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    wait_done("run_ignore_done", 200);
    d0 = done_seen;
    repeat (10) @(posedge clk);
    #1;
    check("no_extra_run", 32'(done_seen - d0), 32'd0);
    directed_queues();
    pulse_start(2);
    wait_done("run_after_ignore_done", 200);

    // reset while the second image byte is on the bus
    ready_mode = 4;
    bus.tx_ready = 1'b0;
    directed_queues();
    pulse_start(2);
    n = 0;
    while (!bus.tx_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("saw_tx_valid", 32'(bus.tx_valid), 32'd1);
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
    check("second_byte_pending", 32'(bus.tx_valid), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_ops.delete();
    exp_bytes.delete();
    for (int i = 0; i < PD; i++) model_prog[i] = '0;
    check_idle_outputs("abort");
    ready_mode = 0;
    for (int i = 0; i < PD; i++) img_for_op[i] = $urandom;
    build_model(4);
    pulse_start(4);
    wait_done("run_post_reset_done", 300);

    // randomized runs, including clamped and zero op counts
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < PD; i++) begin
        prog_write(i, 16'($urandom));
        img_for_op[i] = $urandom;
      end
      ready_mode = $urandom_range(0, 2);
      n = $urandom_range(0, 7);
      build_model(n);
      pulse_start(n);
      wait_done("run_random_done", 500);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/morph_debug_sequencer.md
MORPH_DEBUG_SEQUENCER -- requirements
Module: morph_debug_sequencer

Interface
REQ-001 Parameter ImageWidth, default 8, pixels per image row.
REQ-002 Parameter ImageHeight, default 4, image rows; ImageWidth*ImageHeight SHALL be a multiple of 8.
REQ-003 Parameter ProgramDepth, default 4, opcode slots; power of two, at least 2; AW = log2(ProgramDepth).
REQ-004 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program slot index.
- prog_data  in  16  opcode: {el[8:0], morphOp[2:0], morphInSelect, logicOp[2:0]}.
- start  in  1  run request, one-cycle pulse.
- op_count  in  AW+1  number of opcodes to run, sampled with start.
- proc_ce  out  1  one-cycle issue strobe to the processor.
- proc_opcode  out  16  opcode being issued.
- proc_done  in  1  processor result-valid pulse.
- proc_image  in  ImageWidth*ImageHeight  processor accumulator image.
- tx_data  out  8  result byte.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  sink accepts the byte.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle run-complete pulse.

Function
REQ-005 States: IDLE, ISSUE, WAIT, HDR (macro only), SEND, FIN.
REQ-006 IDLE: when prog_we=1, prog_data SHALL be written to slot prog_addr on that edge. prog_we SHALL be ignored in every other state.
REQ-007 IDLE with start=1: latch op_count and clear index i to 0.
- op_count=0 -> FIN.
- op_count>ProgramDepth -> clamp to ProgramDepth.
- Otherwise -> ISSUE.
REQ-008 ISSUE: proc_ce=1 and proc_opcode=prog[i] for exactly one cycle, then WAIT. proc_opcode SHALL hold prog[i] through WAIT.
REQ-009 WAIT: on proc_done=1, if i<count-1 then i+1 and go to ISSUE. If i=count-1, capture proc_image into the shift register and go to HDR (macro defined) or SEND.
REQ-010 Step latency: proc_ce for opcode i+1 SHALL assert exactly 2 cycles after the proc_done for opcode i.
REQ-011 SEND: bytes go out most-significant first, so byte k = image bits [N-1-8k : N-8-8k] with N=ImageWidth*ImageHeight.
- Transfer occurs on a cycle with tx_valid=1 and tx_ready=1.
- tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
- tx_valid SHALL never drop before the transfer.
REQ-012 The next byte SHALL be presented on the cycle after each transfer (back-to-back capable). After byte N/8-1 transfers -> FIN.
REQ-013 FIN: done=1 for one cycle, then IDLE.
REQ-014 start asserted while busy=1 SHALL be ignored. proc_done outside WAIT SHALL be ignored.
REQ-015 tx_valid=0 in every state except HDR and SEND. proc_ce=0 in every state except ISSUE.

Reset
REQ-016 On a clk edge with rst=0: state=IDLE, i=0, count=0, all program slots=0, shift register=0. Outputs: proc_ce=0, proc_opcode=0, tx_valid=0, tx_data=0, busy=0, done=0.
REQ-017 Reset SHALL abort any run at any state, including mid-byte with tx_valid=1. tx_valid SHALL be 0 on the cycle after the reset edge.

Configuration
REQ-018 Macro MORPH_DEBUG_HEADER_EN, when defined, SHALL enable the HDR state. HDR sends byte 0xA5, then byte {op_count latched, zero-extended to 8 bits}, with the SEND handshake rules, before the image bytes. When op_count=0, the run goes IDLE -> HDR -> FIN: both header bytes sent, no image bytes.
REQ-019 Without the macro, HDR SHALL not exist. Exactly N/8 bytes per run, and zero bytes when op_count=0.

Verification
REQ-020 Defaults; program slot0=0x5D11, slot1=0x4911; start, op_count=2; proc_done 3 cycles after each proc_ce; proc_image=0x00301800; tx_ready=1 -> two proc_ce pulses with opcodes 0x5D11 then 0x4911; bytes 0x00,0x30,0x18,0x00; one done pulse.
REQ-021 Same run with tx_ready toggling 1,0,0,1 per cycle -> tx_data stable while stalled; same 4 bytes, no duplicates or drops.
REQ-022 op_count=0 -> no proc_ce, no bytes (macro off); done pulse 2 cycles after start.
REQ-023 start and prog_we pulsed during WAIT -> ignored; program contents unchanged; run completes as REQ-020.
REQ-024 rst=0 during the second SEND byte -> next cycle tx_valid=0, busy=0, all slots read back 0; a new run then issues opcode 0x0000.
REQ-025 MORPH_DEBUG_HEADER_EN defined, REQ-020 stimulus -> bytes 0xA5,0x02,0x00,0x30,0x18,0x00.
